// File: rtl/uart_rx.sv
// UART receiver: oversampled start/data/parity/stop deserializer with
// three-sample majority vote, one-cycle valid/error pulses.
module uart_rx #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [5:0]            PRESCALE,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  DATA_VALID,
  output logic                  PAR_ERR,
  output logic                  STP_ERR
);

  localparam int unsigned CNT_W = 6;
  localparam int unsigned BIT_W = $clog2(DATA_WIDTH + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    OUT    = 3'd5
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      edge_q, edge_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [2:0]            samp_q, samp_d;
  logic [CNT_W-1:0]      pre_q, pre_d;
  logic                  par_en_q, par_en_d;
  logic                  par_typ_q, par_typ_d;
  logic                  par_flag_q, par_flag_d;
  logic [DATA_WIDTH-1:0] p_data_d;
  logic                  dv_d, pe_d, se_d;

  logic [CNT_W-1:0]      half;
  logic                  last_edge;
  logic                  vote;
  logic                  par_exp;

  // Per-bit timing helpers and the 2-of-3 vote over the mid-bit samples
  always_comb begin
    half      = {1'b0, pre_q[CNT_W-1:1]};
    last_edge = (edge_q == pre_q - CNT_W'(1));
    vote      = (samp_q[0] & samp_q[1]) | (samp_q[0] & samp_q[2]) | (samp_q[1] & samp_q[2]);
    par_exp   = par_typ_q ? (^shreg_q) : (~^shreg_q);
  end

  // Next-state, datapath and output-pulse decode
  always_comb begin
    state_d    = state_q;
    edge_d     = edge_q;
    bit_d      = bit_q;
    shreg_d    = shreg_q;
    samp_d     = samp_q;
    pre_d      = pre_q;
    par_en_d   = par_en_q;
    par_typ_d  = par_typ_q;
    par_flag_d = par_flag_q;
    p_data_d   = P_DATA;
    dv_d       = 1'b0;
    pe_d       = 1'b0;
    se_d       = 1'b0;

    // Bit-period counter and mid-bit sampling while inside a frame
    if (state_q == START || state_q == DATA || state_q == PARITY || state_q == STOP) begin
      edge_d = last_edge ? '0 : edge_q + CNT_W'(1);
      if (edge_q == half - CNT_W'(1)) samp_d[0] = RX_IN;
      if (edge_q == half)             samp_d[1] = RX_IN;
      if (edge_q == half + CNT_W'(1)) samp_d[2] = RX_IN;
    end

    case (state_q)
      IDLE: begin
        // Falling-edge cycle is edge 0, so the counter resumes at 1
        if (!RX_IN) begin
          state_d    = START;
          edge_d     = CNT_W'(1);
          bit_d      = '0;
          pre_d      = PRESCALE;
          par_en_d   = PAR_EN;
          par_typ_d  = PAR_TYP;
          par_flag_d = 1'b0;
        end
      end
      START: begin
        if (last_edge) state_d = vote ? IDLE : DATA;
      end
      DATA: begin
        if (last_edge) begin
          shreg_d = {vote, shreg_q[DATA_WIDTH-1:1]};
          if (bit_q == BIT_W'(DATA_WIDTH - 1)) begin
            bit_d   = '0;
            state_d = par_en_q ? PARITY : STOP;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
      PARITY: begin
        if (last_edge) begin
          if (vote != par_exp) par_flag_d = 1'b1;
          state_d = STOP;
        end
      end
      STOP: begin
        // Outputs are registered on entry to OUT so the pulse lands in the OUT cycle
        if (last_edge) begin
          state_d = OUT;
          if (!vote) begin
            se_d = 1'b1;
          end else if (par_flag_q) begin
            pe_d = 1'b1;
          end else begin
            dv_d     = 1'b1;
            p_data_d = shreg_q;
          end
        end
      end
      OUT: begin
        // A low line here is edge 0 of a back-to-back frame
        if (!RX_IN) begin
          state_d    = START;
          edge_d     = CNT_W'(1);
          bit_d      = '0;
          pre_d      = PRESCALE;
          par_en_d   = PAR_EN;
          par_typ_d  = PAR_TYP;
          par_flag_d = 1'b0;
        end else begin
          state_d = IDLE;
          edge_d  = '0;
        end
      end
      default: begin
        state_d = IDLE;
        edge_d  = '0;
      end
    endcase
  end

  // State, datapath and output registers
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= IDLE;
      edge_q     <= '0;
      bit_q      <= '0;
      shreg_q    <= '0;
      samp_q     <= '0;
      pre_q      <= '0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      par_flag_q <= 1'b0;
      P_DATA     <= '0;
      DATA_VALID <= 1'b0;
      PAR_ERR    <= 1'b0;
      STP_ERR    <= 1'b0;
    end else begin
      state_q    <= state_d;
      edge_q     <= edge_d;
      bit_q      <= bit_d;
      shreg_q    <= shreg_d;
      samp_q     <= samp_d;
      pre_q      <= pre_d;
      par_en_q   <= par_en_d;
      par_typ_q  <= par_typ_d;
      par_flag_q <= par_flag_d;
      P_DATA     <= p_data_d;
      DATA_VALID <= dv_d;
      PAR_ERR    <= pe_d;
      STP_ERR    <= se_d;
    end
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver that sits directly downstream of the team's UART transmitter and consumes its `TX_OUT` line. It oversamples `RX_IN` by a run-time prescale and takes a majority vote of three mid-bit samples. It deserializes start / 8 data (LSB first) / optional parity / stop frames and presents the byte on `P_DATA` with a one-cycle `DATA_VALID` pulse. Parity and stop-bit failures are flagged, and the byte is discarded.

## Interface
- `DATA_WIDTH`, default 8: data bits per frame.
- `CLK`  in  1: receiver clock, running at PRESCALE × baud.
- `RST`  in  1: asynchronous, active-low reset.
- `RX_IN`  in  1: serial line; idles high.
- `PRESCALE`  in  6: oversampling ratio. Legal values are 8, 16 and 32; other values are unsupported.
- `PAR_EN`  in  1: 1 means a parity bit follows the data bits.
- `PAR_TYP`  in  1: selects the parity formula (see Operation).
- `P_DATA`  out  DATA_WIDTH: last good byte; held until the next good frame.
- `DATA_VALID`  out  1: one-cycle pulse when `P_DATA` is updated.
- `PAR_ERR`  out  1: one-cycle pulse when a parity mismatch occurs.
- `STP_ERR`  out  1: one-cycle pulse when the stop bit is sampled as 0.

## Operation
- Reset: all outputs are 0, FSM is in IDLE, and all counters are 0.
- Registers:
  - `edge_cnt` counts 0..PRESCALE-1.
  - `bit_cnt` counts the bit index within the frame.
  - A shift register accumulates the data bits.
- `PRESCALE`, `PAR_EN` and `PAR_TYP` are captured when leaving IDLE. They are ignored for the rest of the frame.
- Sampling: within each bit, take the `RX_IN` samples at `edge_cnt` = P/2-1, P/2 and P/2+1. The sampled bit is the 2-of-3 majority, valid from `edge_cnt` = P/2+2.
- FSM states: IDLE, START, DATA, PARITY, STOP, OUT.
  - **IDLE:** when `RX_IN`=0, go to START with `edge_cnt`=0. The falling-edge cycle counts as edge 0.
  - **START:** at `edge_cnt`=P-1, go to DATA if the sampled bit is 0. If the sampled bit is 1 (glitch), go to IDLE; nothing is flagged.
  - **DATA:** shift each sampled bit in LSB first. After bit DATA_WIDTH-1, at `edge_cnt`=P-1, go to PARITY if `PAR_EN`=1, otherwise go to STOP.
  - **PARITY:** the expected parity bit is `~^data` when `PAR_TYP`=0 and `^data` when `PAR_TYP`=1. This matches the team's UART transmitter. At `edge_cnt`=P-1, record any mismatch in a sticky internal flag, then go to STOP.
  - **STOP:** at `edge_cnt`=P-1, go to OUT.
  - **OUT** (exactly one cycle):
    - If the stop bit sampled as 0, pulse `STP_ERR`.
    - Else if the parity flag is set, pulse `PAR_ERR`.
    - Otherwise load `P_DATA` and pulse `DATA_VALID`.
    - Exits: go to START if `RX_IN`=0 this cycle (back-to-back frame; this cycle counts as edge 0), else go to IDLE.
- Error priority: only one of the three pulses fires per frame, with stop error taking precedence over parity error. `P_DATA` is not updated on an error.
- The sticky parity flag clears on entry to START.
- Reset mid-frame: the frame is aborted immediately, outputs return to 0, and the partial byte is lost. No pulse is produced after reset release until a full new frame is received.

## Timing
- Frame length is N = 10 bits (`PAR_EN`=0) or 11 bits (`PAR_EN`=1), i.e. N×P clocks.
- Latency: the output pulse appears in the cycle after the last stop-bit edge (`edge_cnt`=P-1). That is N×P clocks after the `RX_IN` falling edge is first seen low in IDLE.
- Output pulse width is exactly 1 clock. Output pulses are never asserted in consecutive cycles.
- The OUT cycle overlaps the first edge of the next frame, so continuous frames with no idle are received without slip.
- Tolerance: ±1 clock of phase error per bit is absorbed by the 3-sample window.

## Test plan
- **Good frame, parity on.** P=8, `PAR_EN`=1, `PAR_TYP`=0, send 0x55 with parity bit 1 and stop bit 1. Expect `DATA_VALID` high for 1 cycle, 88 clocks after the start edge; `P_DATA`=0x55; no error pulses.
- **Parity error.** P=16, `PAR_EN`=1, `PAR_TYP`=1, send 0x57 with parity bit 0. Expect `PAR_ERR` pulsed once, no `DATA_VALID`, and `P_DATA` keeping its previous value.
- **Stop error dominates.** P=8, `PAR_EN`=1, send 0x55 with a bad parity bit and stop bit 0. Expect only `STP_ERR` pulsed, 88 clocks after the start edge.
- **Start glitch.** P=16, drive `RX_IN` low for 3 clocks, then high. Expect the FSM back in IDLE after 16 clocks and no output pulses; a following good frame with 0xA5 must be received correctly.
- **Back-to-back frames.** P=32, `PAR_EN`=0, send 0xA3 then 0x3C with no idle between them. Expect two `DATA_VALID` pulses exactly 320 clocks apart, with `P_DATA` = 0xA3 then 0x3C.
- **Reset mid-frame.** Assert `RST` low during data bit 4, release it, then send 0x0F. Expect all outputs 0 while in reset, no pulse for the aborted frame, and a single `DATA_VALID` with `P_DATA`=0x0F.
